// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcodes, NOP word,
// reset PC, FSM encoding and IF/ID update selects.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] IFID_HOLD = 2'd0;
  localparam logic [1:0] IFID_MEM  = 2'd1;
  localparam logic [1:0] IFID_SKID = 2'd2;
  localparam logic [1:0] IFID_NOP  = 2'd3;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that returned while the
// downstream stage was stalled.
module fetch_skid_buf
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output logic        valid,
  output logic [31:0] held_instr,
  output logic [31:0] held_pc_plus4
);

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;

  // Entry storage; clear wins over load so a redirect always discards the word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_r    <= 1'b0;
      instr_r    <= NOP_WORD;
      pc_plus4_r <= 32'h0000_0000;
    end else if (load) begin
      valid_r    <= 1'b1;
      instr_r    <= instr;
      pc_plus4_r <= pc_plus4;
    end else begin
      valid_r    <= valid_r;
      instr_r    <= instr_r;
      pc_plus4_r <= pc_plus4_r;
    end
  end

  assign valid         = valid_r;
  assign held_instr    = instr_r;
  assign held_pc_plus4 = pc_plus4_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction memory, handles stalls via a
// skid buffer and branch redirects (draining any outstanding request).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  instr_op
);

  logic [1:0]  state_r;
  logic [1:0]  state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic        req_r;
  logic        req_nxt_s;
  logic [31:0] addr_r;
  logic [31:0] addr_nxt_s;
  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_plus4_r;
  logic [1:0]  ifid_sel_s;
  logic        ack_s;
  logic        skid_load_s;
  logic        skid_clear_s;
  logic        skid_valid_s;
  logic [31:0] skid_instr_s;
  logic [31:0] skid_pc_plus4_s;

  // An ack only counts while a request is actually on the bus.
  assign ack_s = imem_ack & req_r;

  fetch_skid_buf u_skid (
    .clk           (clk),
    .rst           (rst),
    .load          (skid_load_s),
    .clear         (skid_clear_s),
    .instr         (imem_rdata),
    .pc_plus4      (pc_inc(pc_r)),
    .valid         (skid_valid_s),
    .held_instr    (skid_instr_s),
    .held_pc_plus4 (skid_pc_plus4_s)
  );

  // Next-state, next-pc, request and IF/ID update selection.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    req_nxt_s    = req_r;
    addr_nxt_s   = addr_r;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    ifid_sel_s   = stall ? IFID_HOLD : IFID_NOP;
    if (branch_taken) begin
      pc_nxt_s     = word_align(branch_target);
      ifid_sel_s   = IFID_NOP;
      skid_clear_s = 1'b1;
      // An unanswered request must complete at its old address before redirecting.
      if (req_r && !ack_s && (state_r == ST_FETCH || state_r == ST_DRAIN)) begin
        state_nxt_s = ST_DRAIN;
      end else begin
        state_nxt_s = ST_FETCH;
        req_nxt_s   = 1'b1;
        addr_nxt_s  = word_align(branch_target);
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          req_nxt_s = 1'b1;
          if (ack_s) begin
            pc_nxt_s   = pc_inc(pc_r);
            addr_nxt_s = pc_inc(pc_r);
            if (stall) begin
              skid_load_s = 1'b1;
              state_nxt_s = ST_HOLD;
              req_nxt_s   = 1'b0;
            end else begin
              ifid_sel_s  = IFID_MEM;
            end
          end else begin
            addr_nxt_s = pc_r;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_sel_s   = IFID_SKID;
            skid_clear_s = 1'b1;
            state_nxt_s  = ST_FETCH;
            req_nxt_s    = 1'b1;
            addr_nxt_s   = pc_r;
          end else begin
            req_nxt_s    = 1'b0;
          end
        end
        ST_DRAIN: begin
          if (ack_s) begin
            state_nxt_s = ST_FETCH;
            addr_nxt_s  = pc_r;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_FETCH;
          req_nxt_s   = 1'b0;
          addr_nxt_s  = pc_r;
        end
      endcase
    end
  end

  // FSM, pc and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
      req_r   <= 1'b0;
      addr_r  <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      req_r   <= req_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

  // IF/ID pipeline register; an invalid slot always carries the NOP word.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      instr_r    <= NOP_WORD;
      pc_plus4_r <= 32'h0000_0000;
    end else begin
      case (ifid_sel_s)
        IFID_MEM: begin
          valid_r    <= 1'b1;
          instr_r    <= imem_rdata;
          pc_plus4_r <= pc_inc(pc_r);
        end
        IFID_SKID: begin
          valid_r    <= skid_valid_s;
          instr_r    <= skid_valid_s ? skid_instr_s : NOP_WORD;
          pc_plus4_r <= skid_pc_plus4_s;
        end
        IFID_NOP: begin
          valid_r    <= 1'b0;
          instr_r    <= NOP_WORD;
          pc_plus4_r <= pc_plus4_r;
        end
        default: begin
          valid_r    <= valid_r;
          instr_r    <= instr_r;
          pc_plus4_r <= pc_plus4_r;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = addr_r;
  assign if_valid    = valid_r;
  assign if_instr    = instr_r;
  assign if_pc_plus4 = pc_plus4_r;
  assign instr_op    = instr_r[31:26];

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch byte address; word-aligned.
- imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- stall  in  1  downstream hold request; IF/ID must not change.
- branch_taken  in  1  one-cycle redirect pulse.
- branch_target  in  32  redirect address; valid with branch_taken.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  32  IF/ID instruction word.
- if_pc_plus4  out  32  IF/ID PC+4 of if_instr.
- instr_op  out  6  if_instr[31:26]; feeds control-unit opcode input.

Function
REQ-003 SHALL implement FSM states FETCH, HOLD and DRAIN, with registered pc[31:0].
REQ-004 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_addr SHALL stay stable until imem_ack.
REQ-005 imem_ack SHALL be accepted in any cycle where imem_req=1, including the first one.
REQ-006 FETCH with ack, stall=0, branch_taken=0:
- IF/ID <= {rdata, pc+4}; if_valid<=1.
- pc<=pc+4; stay in FETCH.
- Zero-wait memory SHALL sustain 1 instruction/cycle.
REQ-007 FETCH with ack, stall=1, branch_taken=0:
- rdata and pc+4 go to the skid buffer; pc<=pc+4; go to HOLD.
- IF/ID stays unchanged.
REQ-008 In HOLD, imem_req SHALL be 0. On stall=0, the skid contents SHALL load IF/ID with if_valid=1, and the FSM SHALL return to FETCH.
REQ-009 stall=1 without ack SHALL leave IF/ID unchanged. Fetching continues per REQ-004.
REQ-010 branch_taken=1 SHALL take priority over stall and ack in every state:
- pc<=branch_target.
- if_valid<=0 and if_instr<=32'h0000_0000 (NOP), even when stall=1.
- Skid buffer discarded.
REQ-011 branch_taken in FETCH with no ack that cycle (request outstanding) SHALL go to DRAIN. branch_taken in FETCH with ack that cycle SHALL discard rdata and stay in FETCH.
REQ-012 In DRAIN:
- imem_req SHALL be 1 and imem_addr SHALL hold the old address.
- On ack, rdata is discarded and the FSM goes to FETCH at the new pc.
- A further branch_taken in DRAIN SHALL overwrite pc and stay in DRAIN.
REQ-013 branch_taken in HOLD SHALL go to FETCH at branch_target.
REQ-014 pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-015 When if_valid=0, if_instr SHALL be 0. instr_op is therefore 6'b000000 with a NOP body, which the downstream control unit decodes harmlessly.
REQ-016 All outputs SHALL be registered except instr_op, which is a pure wire slice.

Reset
REQ-017 On rst:
- pc<=RESET_PC; FSM<=FETCH.
- imem_req=0; imem_addr=RESET_PC.
- if_valid=0; if_instr=0; if_pc_plus4=0; skid cleared.
REQ-018 imem_req SHALL rise in the first cycle after rst deasserts. imem_ack during rst SHALL be ignored.
REQ-019 rst asserted mid-fetch, in HOLD or in DRAIN SHALL abandon all state without draining. Memory is reset by the same rst.

Structure
REQ-020 The shared package SHALL hold:
- opcode localparams (R, LW, SW, BEQ, ADDI);
- NOP word 32'h0;
- RESET_PC default;
- the FSM state encoding.
REQ-021 The skid buffer SHALL be a sub-module, fetch_skid_buf: one-entry data+pc+4 register with load/clear/valid.

Verification
REQ-022 Reset release, zero-wait memory returning 32'h8C01_0004, 32'h0022_1820:
- imem_addr 0, 4, 8 on consecutive cycles.
- if_instr follows one cycle after each ack.
- instr_op shows 6'b100011, then 6'b000000.
REQ-023 stall=1 for 3 cycles while ack returns 32'hAC01_0008 at pc=8:
- IF/ID frozen.
- imem_req=0 during HOLD.
- One cycle after stall falls, if_instr=32'hAC01_0008 and if_pc_plus4=12.
REQ-024 Memory with 2 wait states; branch_taken with branch_target=32'h40 one cycle after req:
- DRAIN until ack; old word discarded.
- Next imem_addr=32'h40; if_valid=0 meanwhile.
REQ-025 branch_taken, ack and stall all high in one cycle:
- if_valid=0 and if_instr=0 next cycle.
- Next imem_addr=branch_target.
REQ-026 pc preloaded via branch to 32'hFFFF_FFFC:
- Fetch there.
- if_pc_plus4=0 and next imem_addr=0.
REQ-027 rst asserted for 1 cycle while in DRAIN:
- All outputs reset per REQ-017.
- A late ack is ignored; first fetch is at RESET_PC.
